// File: rtl/instr_fsm.sv
// Controller FSM for the Simple RISC Machine: latches opcode/op on a start
// strobe and walks the datapath through the per-instruction strobe sequence.
module instr_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic       bad,
    output logic [2:0] nsel,
    output logic       loada,
    output logic       loadb,
    output logic       asel,
    output logic       bsel,
    output logic       loadc,
    output logic       loads,
    output logic [1:0] vsel,
    output logic       write
);

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_DECODE,
        ST_GETA,
        ST_GETB,
        ST_ALU,
        ST_WRITEREG,
        ST_WRITEIMM
    } state_t;

    localparam logic [2:0] NSEL_RN   = 3'b100;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b001;
    localparam logic [1:0] VSEL_IMM8 = 2'b01;
    localparam logic [1:0] VSEL_C    = 2'b11;

    state_t     state_reg, state_next;
    logic [2:0] opcode_reg, opcode_next;
    logic [1:0] op_reg, op_next;

    // Instruction class from the latched copy only, so upstream may move on
    // to the next instruction word as soon as the start edge has passed.
    logic is_movi, is_movr, is_add, is_and, is_cmp, is_mvn, is_supported;

    always_comb begin
        is_movi      = (opcode_reg == 3'b110) && (op_reg == 2'b10);
        is_movr      = (opcode_reg == 3'b110) && (op_reg == 2'b00);
        is_add       = (opcode_reg == 3'b101) && (op_reg == 2'b00);
        is_and       = (opcode_reg == 3'b101) && (op_reg == 2'b10);
        is_cmp       = (opcode_reg == 3'b101) && (op_reg == 2'b01);
        is_mvn       = (opcode_reg == 3'b101) && (op_reg == 2'b11);
        is_supported = is_movi | is_movr | is_add | is_and | is_cmp | is_mvn;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_WAIT;
            opcode_reg <= 3'b000;
            op_reg     <= 2'b00;
        end else begin
            state_reg  <= state_next;
            opcode_reg <= opcode_next;
            op_reg     <= op_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        opcode_next = opcode_reg;
        op_next     = op_reg;
        case (state_reg)
            ST_WAIT: begin
                if (s) begin
                    state_next  = ST_DECODE;
                    opcode_next = opcode;
                    op_next     = op;
                end
            end
            ST_DECODE: begin
                if (is_movi)
                    state_next = ST_WRITEIMM;
                else if (is_movr || is_mvn)
                    state_next = ST_GETB;
                else if (is_add || is_and || is_cmp)
                    state_next = ST_GETA;
                else
                    state_next = ST_WAIT;
            end
            ST_GETA:     state_next = ST_GETB;
            ST_GETB:     state_next = ST_ALU;
            // CMP only updates status, so it has no writeback step.
            ST_ALU:      state_next = is_cmp ? ST_WAIT : ST_WRITEREG;
            ST_WRITEREG: state_next = ST_WAIT;
            ST_WRITEIMM: state_next = ST_WAIT;
            default:     state_next = ST_WAIT;
        endcase
    end

    always_comb begin
        w     = 1'b0;
        bad   = 1'b0;
        nsel  = 3'b000;
        loada = 1'b0;
        loadb = 1'b0;
        asel  = 1'b0;
        bsel  = 1'b0;
        loadc = 1'b0;
        loads = 1'b0;
        vsel  = 2'b00;
        write = 1'b0;
        case (state_reg)
            ST_WAIT:   w   = 1'b1;
            ST_DECODE: bad = ~is_supported;
            ST_GETA: begin
                nsel  = NSEL_RN;
                loada = 1'b1;
            end
            ST_GETB: begin
                nsel  = NSEL_RM;
                loadb = 1'b1;
            end
            ST_ALU: begin
                loadc = ~is_cmp;
                loads = is_cmp;
                // Single-operand ops never load A, so zero it at the ALU.
                asel  = is_movr | is_mvn;
            end
            ST_WRITEREG: begin
                nsel  = NSEL_RD;
                vsel  = VSEL_C;
                write = 1'b1;
            end
            ST_WRITEIMM: begin
                nsel  = NSEL_RN;
                vsel  = VSEL_IMM8;
                write = 1'b1;
            end
            default: w = 1'b0;
        endcase
    end

endmodule
